// File: rtl/udp_pkg.sv
// Shared UDP/IPv4 framing constants and FSM state encoding for the RX and TX paths.
package udp_pkg;

  typedef enum logic [6:0] {
    st_idle     = 7'b000_0001,
    st_preamble = 7'b000_0010,
    st_eth_head = 7'b000_0100,
    st_ip_head  = 7'b000_1000,
    st_udp_head = 7'b001_0000,
    st_rx_data  = 7'b010_0000,
    st_rx_end   = 7'b100_0000
  } state_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [47:0] BROADCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;

  localparam int unsigned ETH_HDR_LEN   = 14;
  localparam int unsigned UDP_HDR_LEN   = 8;
  // Bytes seen in st_preamble: six more 0x55 followed by the SFD.
  localparam int unsigned PREAMBLE_LEN  = 7;

  localparam logic [3:0]  IP_VERSION    = 4'd4;
  localparam logic [3:0]  IP_MIN_IHL    = 4'd5;

  // IPv4 header length in bytes from the IHL field (32-bit words).
  function automatic logic [5:0] ip_hdr_bytes(input logic [3:0] ihl);
    return {ihl, 2'b00};
  endfunction

endpackage

// File: rtl/udp_rx_packer.sv
// Packs a byte stream into 32-bit big-endian words; a last byte flushes a
// partial word left-aligned with zero fill.
module udp_rx_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic        o_word_vld,
  output logic [31:0] o_word
);

  logic [31:0] r_buf;
  logic [1:0]  r_idx;
  logic [31:0] w_fill;

  // Merge the incoming byte into the partial word at the current position.
  always_comb begin
    w_fill = r_buf;
    case (r_idx)
      2'd0: w_fill[31:24] = i_byte;
      2'd1: w_fill[23:16] = i_byte;
      2'd2: w_fill[15:8]  = i_byte;
      2'd3: w_fill[7:0]   = i_byte;
    endcase
  end

  // Accumulate bytes; emit a word on the fourth byte or on the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf      <= '0;
      r_idx      <= '0;
      o_word_vld <= 1'b0;
      o_word     <= '0;
    end else begin
      o_word_vld <= 1'b0;
      if (i_clr) begin
        r_buf <= '0;
        r_idx <= '0;
      end else if (i_byte_vld) begin
        if (r_idx == 2'd3 || i_last) begin
          o_word     <= w_fill;
          o_word_vld <= 1'b1;
          r_buf      <= '0;
          r_idx      <= '0;
        end else begin
          r_buf <= w_fill;
          r_idx <= r_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/udp_rx.sv
// GMII receive-side UDP/IPv4 parser: validates preamble, Ethernet, IPv4 and
// UDP headers and streams the UDP payload as 32-bit big-endian words.
module udp_rx
  import udp_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        rec_en,
  output logic [31:0] rec_data,
  output logic        rec_pkt_done,
  output logic [15:0] rec_byte_num
);

  state_t      r_state;
  // 6 bits so a maximum-length IPv4 header (IHL=15, 60 bytes) can be counted.
  logic [5:0]  r_cnt;
  logic [39:0] r_da;
  logic [7:0]  r_type_hi;
  logic [5:0]  r_ip_hlen;
  logic [23:0] r_dip;
  logic [15:0] r_udp_len;
  logic [15:0] r_data_byte_num;
  logic [15:0] r_data_cnt;

  logic        w_mac_miss;
  logic        w_ip_fail;
  logic        w_byte_vld;
  logic        w_last;
  logic        w_clr;

  // Header field checks and payload byte qualification for the current byte.
  always_comb begin
    w_mac_miss = (r_cnt == 6'd5) &&
                 ({r_da, gmii_rxd} != BOARD_MAC) &&
                 ({r_da, gmii_rxd} != BROADCAST_MAC);
    w_ip_fail  = ((r_cnt == 6'd0) &&
                  ((gmii_rxd[7:4] != IP_VERSION) || (gmii_rxd[3:0] < IP_MIN_IHL))) ||
                 ((r_cnt == 6'd9)  && (gmii_rxd != IP_PROTO_UDP)) ||
                 ((r_cnt == 6'd19) && ({r_dip, gmii_rxd} != BOARD_IP));
    w_byte_vld = (r_state == st_rx_data) && gmii_rx_dv;
    w_last     = w_byte_vld && (r_data_cnt == r_data_byte_num - 16'd1);
    w_clr      = (r_state != st_rx_data);
  end

  // Header-parsing FSM with registered completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= st_idle;
      r_cnt           <= '0;
      r_da            <= '0;
      r_type_hi       <= '0;
      r_ip_hlen       <= '0;
      r_dip           <= '0;
      r_udp_len       <= '0;
      r_data_byte_num <= '0;
      r_data_cnt      <= '0;
      rec_pkt_done    <= 1'b0;
      rec_byte_num    <= '0;
    end else begin
      rec_pkt_done <= 1'b0;
      r_cnt        <= r_cnt + 6'd1;
      unique case (r_state)
        st_idle: begin
          r_cnt <= '0;
          if (gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE) r_state <= st_preamble;
        end

        st_preamble: begin
          if (!gmii_rx_dv) begin
            r_cnt   <= '0;
            r_state <= st_idle;
          end else if (r_cnt == 6'(PREAMBLE_LEN - 1)) begin
            r_cnt   <= '0;
            r_state <= (gmii_rxd == SFD_BYTE) ? st_eth_head : st_rx_end;
          end else if (gmii_rxd != PREAMBLE_BYTE) begin
            r_cnt   <= '0;
            r_state <= st_rx_end;
          end
        end

        st_eth_head: begin
          if (!gmii_rx_dv) begin
            r_cnt   <= '0;
            r_state <= st_idle;
          end else begin
            if (r_cnt < 6'd5)  r_da      <= {r_da[31:0], gmii_rxd};
            if (r_cnt == 6'd12) r_type_hi <= gmii_rxd;
            if (w_mac_miss) begin
              r_cnt   <= '0;
              r_state <= st_rx_end;
            end else if (r_cnt == 6'(ETH_HDR_LEN - 1)) begin
              r_cnt   <= '0;
              r_state <= ({r_type_hi, gmii_rxd} == ETH_TYPE_IPV4) ? st_ip_head : st_rx_end;
            end
          end
        end

        st_ip_head: begin
          if (!gmii_rx_dv) begin
            r_cnt   <= '0;
            r_state <= st_idle;
          end else begin
            if (r_cnt == 6'd0) r_ip_hlen <= ip_hdr_bytes(gmii_rxd[3:0]);
            if (r_cnt >= 6'd16 && r_cnt <= 6'd18) r_dip <= {r_dip[15:0], gmii_rxd};
            if (w_ip_fail) begin
              r_cnt   <= '0;
              r_state <= st_rx_end;
            end else if (r_cnt >= 6'd19 && r_cnt == r_ip_hlen - 6'd1) begin
              r_cnt   <= '0;
              r_state <= st_udp_head;
            end
          end
        end

        st_udp_head: begin
          if (!gmii_rx_dv) begin
            r_cnt   <= '0;
            r_state <= st_idle;
          end else begin
            if (r_cnt == 6'd4) r_udp_len[15:8] <= gmii_rxd;
            if (r_cnt == 6'd5) r_udp_len[7:0]  <= gmii_rxd;
            if (r_cnt == 6'(UDP_HDR_LEN - 1)) begin
              r_cnt           <= '0;
              r_data_cnt      <= '0;
              r_data_byte_num <= r_udp_len - 16'(UDP_HDR_LEN);
              if (r_udp_len < 16'(UDP_HDR_LEN)) begin
                r_state <= st_rx_end;
              end else if (r_udp_len == 16'(UDP_HDR_LEN)) begin
                rec_pkt_done <= 1'b1;
                rec_byte_num <= '0;
                r_state      <= st_rx_end;
              end else begin
                r_state <= st_rx_data;
              end
            end
          end
        end

        st_rx_data: begin
          r_cnt <= '0;
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
          end else begin
            r_data_cnt <= r_data_cnt + 16'd1;
            if (w_last) begin
              rec_pkt_done <= 1'b1;
              rec_byte_num <= r_data_byte_num;
              r_state      <= st_rx_end;
            end
          end
        end

        st_rx_end: begin
          r_cnt <= '0;
          if (!gmii_rx_dv) r_state <= st_idle;
        end

        default: begin
          r_cnt   <= '0;
          r_state <= st_idle;
        end
      endcase
    end
  end

  udp_rx_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_byte_vld (w_byte_vld),
    .i_byte     (gmii_rxd),
    .i_last     (w_last),
    .o_word_vld (rec_en),
    .o_word     (rec_data)
  );

endmodule

// File: tb/tb_udp_rx.sv
// Directed bench for udp_rx: builds GMII frames byte by byte and checks the
// received payload words, completion pulse and byte count.
module tb_udp_rx;

  localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] IP  = {8'd192, 8'd168, 8'd1, 8'd123};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0]  frm[$];
  logic [7:0]  pl[$];
  logic [31:0] words[$];
  int unsigned n_done;
  logic [15:0] done_bn;
  logic        done_en;

  logic        snap_en, snap_done;
  logic [31:0] snap_data;
  logic [15:0] snap_bn;

  always #4 clk = ~clk;

  udp_rx #(.BOARD_MAC(MAC), .BOARD_IP(IP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rxd     (gmii_rxd),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num)
  );

  // Collect strobed words and completion info away from the active edge.
  always @(negedge clk) begin
    if (rec_en) words.push_back(rec_data);
    if (rec_pkt_done) begin
      n_done  = n_done + 1;
      done_bn = rec_byte_num;
      done_en = rec_en;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_rx();
    words.delete();
    n_done  = 0;
    done_bn = '0;
    done_en = 1'b0;
  endtask

  task automatic build(input logic [47:0] da, input logic [15:0] et, input logic [3:0] ihl,
                       input logic [7:0] proto, input logic [31:0] dip,
                       input logic [15:0] ulen, input bit bad_sfd);
    logic [15:0] tot;
    tot = {10'd0, ihl, 2'b00} + ulen;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(bad_sfd ? 8'h55 : 8'hD5);
    for (int i = 5; i >= 0; i--) frm.push_back(da[i*8 +: 8]);
    frm.push_back(8'h02); repeat (4) frm.push_back(8'h00); frm.push_back(8'h01);
    frm.push_back(et[15:8]); frm.push_back(et[7:0]);
    frm.push_back({4'd4, ihl}); frm.push_back(8'h00);
    frm.push_back(tot[15:8]); frm.push_back(tot[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h01); frm.push_back(8'h40); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(proto); frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'd192); frm.push_back(8'd168); frm.push_back(8'd1); frm.push_back(8'd10);
    for (int i = 3; i >= 0; i--) frm.push_back(dip[i*8 +: 8]);
    for (int i = 5; i < int'(ihl); i++) repeat (4) frm.push_back(8'h01);
    frm.push_back(8'h12); frm.push_back(8'h34); frm.push_back(8'h56); frm.push_back(8'h78);
    frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    foreach (pl[i]) frm.push_back(pl[i]);
    while (frm.size() < 68) frm.push_back(8'h00);
    repeat (4) frm.push_back(8'hA5);
  endtask

  // Drive the frame; stop_at drops rx_dv early, rst_at pulses reset for one cycle.
  task automatic send(input int stop_at, input int rst_at);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == stop_at) break;
      @(negedge clk);
      if (i == rst_at) rst_n = 1'b0;
      if (i == rst_at + 1) begin
        snap_en   = rec_en;
        snap_done = rec_pkt_done;
        snap_data = rec_data;
        snap_bn   = rec_byte_num;
        rst_n     = 1'b1;
      end
      gmii_rx_dv = 1'b1;
      gmii_rxd   = frm[i];
    end
    @(negedge clk);
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    repeat (6) @(negedge clk);
  endtask

  task automatic expect_none(input string tag);
    chk({tag, "_words"}, 32'(words.size()), 32'd0);
    chk({tag, "_done"},  32'(n_done),       32'd0);
  endtask

  task automatic expect_one(input string tag, input logic [31:0] w, input logic [15:0] bn);
    chk({tag, "_words"}, 32'(words.size()), 32'd1);
    if (words.size() > 0) chk({tag, "_w0"}, words[0], w);
    chk({tag, "_done"},  32'(n_done), 32'd1);
    chk({tag, "_bn"},    32'(done_bn), 32'(bn));
    chk({tag, "_en_at_done"}, 32'(done_en), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    clear_rx();
    repeat (3) @(negedge clk);
    chk("rst_en",   32'(rec_en),       32'd0);
    chk("rst_data", rec_data,          32'd0);
    chk("rst_done", 32'(rec_pkt_done), 32'd0);
    chk("rst_bn",   32'(rec_byte_num), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: unicast, 8-byte payload
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build(MAC, 16'h0800, 4'd5, 8'd17, IP, 16'd16, 1'b0);
    clear_rx(); send(-1, -5);
    chk("t1_words", 32'(words.size()), 32'd2);
    if (words.size() == 2) begin
      chk("t1_w0", words[0], 32'h01020304);
      chk("t1_w1", words[1], 32'h05060708);
    end
    chk("t1_done", 32'(n_done), 32'd1);
    chk("t1_bn", 32'(done_bn), 32'd8);
    chk("t1_en_at_done", 32'(done_en), 32'd1);
    chk("t1_bn_hold", 32'(rec_byte_num), 32'd8);

    // 2: broadcast, 3-byte payload in a padded frame
    pl = '{8'hAA, 8'hBB, 8'hCC};
    build(48'hFF_FF_FF_FF_FF_FF, 16'h0800, 4'd5, 8'd17, IP, 16'd11, 1'b0);
    clear_rx(); send(-1, -5);
    expect_one("t2", 32'hAABBCC00, 16'd3);

    // 3: wrong IP, wrong protocol, wrong EtherType
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    build(MAC, 16'h0800, 4'd5, 8'd17, {8'd192, 8'd168, 8'd1, 8'd50}, 16'd12, 1'b0);
    clear_rx(); send(-1, -5); expect_none("t3_ip");
    build(MAC, 16'h0800, 4'd5, 8'd6, IP, 16'd12, 1'b0);
    clear_rx(); send(-1, -5); expect_none("t3_proto");
    build(MAC, 16'h0806, 4'd5, 8'd17, IP, 16'd12, 1'b0);
    clear_rx(); send(-1, -5); expect_none("t3_etype");
    build(48'h00_11_22_33_44_56, 16'h0800, 4'd5, 8'd17, IP, 16'd12, 1'b0);
    clear_rx(); send(-1, -5); expect_none("t3_mac");

    // 4: IHL=6 with options
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build(MAC, 16'h0800, 4'd6, 8'd17, IP, 16'd12, 1'b0);
    clear_rx(); send(-1, -5);
    expect_one("t4", 32'hDEADBEEF, 16'd4);

    // 5: abort after 2 of 8 payload bytes, then a good frame
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build(MAC, 16'h0800, 4'd5, 8'd17, IP, 16'd16, 1'b0);
    clear_rx(); send(52, -5); expect_none("t5_abort");
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    build(MAC, 16'h0800, 4'd5, 8'd17, IP, 16'd12, 1'b0);
    clear_rx(); send(-1, -5);
    expect_one("t5_good", 32'h11223344, 16'd4);

    // 6a: reset pulsed after 6 payload bytes
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build(MAC, 16'h0800, 4'd5, 8'd17, IP, 16'd16, 1'b0);
    clear_rx(); send(-1, 56);
    chk("t6r_snap_en",   32'(snap_en),   32'd0);
    chk("t6r_snap_done", 32'(snap_done), 32'd0);
    chk("t6r_snap_data", snap_data,      32'd0);
    chk("t6r_snap_bn",   32'(snap_bn),   32'd0);
    chk("t6r_words", 32'(words.size()), 32'd1);
    if (words.size() > 0) chk("t6r_w0", words[0], 32'h01020304);
    chk("t6r_done", 32'(n_done), 32'd0);
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    build(MAC, 16'h0800, 4'd5, 8'd17, IP, 16'd12, 1'b0);
    clear_rx(); send(-1, -5);
    expect_one("t6r_good", 32'h11223344, 16'd4);

    // 6b: bad SFD
    build(MAC, 16'h0800, 4'd5, 8'd17, IP, 16'd12, 1'b1);
    clear_rx(); send(-1, -5); expect_none("t6_sfd");

    // 6c: udp_len == 8, empty payload
    pl.delete();
    build(MAC, 16'h0800, 4'd5, 8'd17, IP, 16'd8, 1'b0);
    clear_rx(); send(-1, -5);
    chk("t6z_words", 32'(words.size()), 32'd0);
    chk("t6z_done", 32'(n_done), 32'd1);
    chk("t6z_bn", 32'(done_bn), 32'd0);
    chk("t6z_en_at_done", 32'(done_en), 32'd0);

    // 6d: udp_len < 8 is rejected
    build(MAC, 16'h0800, 4'd5, 8'd17, IP, 16'd7, 1'b0);
    clear_rx(); send(-1, -5); expect_none("t6_short");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
